// File: rtl/tm1637_responder.sv
// Device-side TM1637 CLK/DIO responder: decodes start/stop, LSB-first bytes and ACKs,
// executes data/address/display commands into a digit RAM, and answers key-scan reads.
module tm1637_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_DIGITS  = 6
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       tm_clk_in,
    input  logic       tm_dio_in,
    output logic       dio_oe,
    input  logic [7:0] key_data,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       display_on,
    output logic [2:0] brightness,
    output logic       frame_done,
    output logic       cmd_err
);

    typedef enum logic [2:0] {IDLE, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP} state_t;
    typedef enum logic [1:0] {FK_IGNORE, FK_ADDR, FK_DISCARD} frame_kind_t;

    localparam logic [3:0] DEPTH = 4'(NUM_DIGITS);

    logic [SYNC_STAGES-1:0] clk_sync_reg, dio_sync_reg;
    logic        clk_prev_reg, dio_prev_reg;
    state_t      state_reg, state_next;
    frame_kind_t frame_kind_reg, frame_kind_next;
    logic [3:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  rx_byte_reg, rx_byte_next;
    logic [7:0]  tx_byte_reg, tx_byte_next;
    logic [3:0]  ptr_reg, ptr_next;
    logic        first_byte_reg, first_byte_next;
    logic        acked_reg, acked_next;
    logic        fixed_reg, fixed_next;
    logic        dio_oe_reg, dio_oe_next;
    logic        display_on_reg, display_on_next;
    logic [2:0]  brightness_reg, brightness_next;
    logic        frame_done_reg, frame_done_next;
    logic        cmd_err_reg, cmd_err_next;

    logic        ram_we;
    logic [2:0]  ram_waddr;
    logic [7:0]  ram_wdata;
    logic [NUM_DIGITS-1:0][7:0] digits;

    logic clk_s, dio_s, clk_rise, clk_fall, start_det, stop_det;

    assign clk_s     = clk_sync_reg[SYNC_STAGES-1];
    assign dio_s     = dio_sync_reg[SYNC_STAGES-1];
    assign clk_rise  = clk_s & ~clk_prev_reg;
    assign clk_fall  = ~clk_s & clk_prev_reg;
    // A DIO edge only counts as start/stop when CLK was high in both samples
    assign start_det = clk_s & clk_prev_reg & ~dio_s & dio_prev_reg;
    assign stop_det  = clk_s & clk_prev_reg & dio_s & ~dio_prev_reg;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_reg   <= '0;
            dio_sync_reg   <= '0;
            clk_prev_reg   <= 1'b0;
            dio_prev_reg   <= 1'b0;
            state_reg      <= IDLE;
            frame_kind_reg <= FK_IGNORE;
            bit_cnt_reg    <= '0;
            rx_byte_reg    <= '0;
            tx_byte_reg    <= '0;
            ptr_reg        <= '0;
            first_byte_reg <= 1'b0;
            acked_reg      <= 1'b0;
            fixed_reg      <= 1'b0;
            dio_oe_reg     <= 1'b0;
            display_on_reg <= 1'b0;
            brightness_reg <= '0;
            frame_done_reg <= 1'b0;
            cmd_err_reg    <= 1'b0;
        end else begin
            clk_sync_reg   <= {clk_sync_reg[SYNC_STAGES-2:0], tm_clk_in};
            dio_sync_reg   <= {dio_sync_reg[SYNC_STAGES-2:0], tm_dio_in};
            clk_prev_reg   <= clk_s;
            dio_prev_reg   <= dio_s;
            state_reg      <= state_next;
            frame_kind_reg <= frame_kind_next;
            bit_cnt_reg    <= bit_cnt_next;
            rx_byte_reg    <= rx_byte_next;
            tx_byte_reg    <= tx_byte_next;
            ptr_reg        <= ptr_next;
            first_byte_reg <= first_byte_next;
            acked_reg      <= acked_next;
            fixed_reg      <= fixed_next;
            dio_oe_reg     <= dio_oe_next;
            display_on_reg <= display_on_next;
            brightness_reg <= brightness_next;
            frame_done_reg <= frame_done_next;
            cmd_err_reg    <= cmd_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        frame_kind_next = frame_kind_reg;
        bit_cnt_next    = bit_cnt_reg;
        rx_byte_next    = rx_byte_reg;
        tx_byte_next    = tx_byte_reg;
        ptr_next        = ptr_reg;
        first_byte_next = first_byte_reg;
        acked_next      = acked_reg;
        fixed_next      = fixed_reg;
        dio_oe_next     = dio_oe_reg;
        display_on_next = display_on_reg;
        brightness_next = brightness_reg;
        frame_done_next = 1'b0;
        cmd_err_next    = 1'b0;
        ram_we          = 1'b0;
        ram_waddr       = ptr_reg[2:0];
        ram_wdata       = rx_byte_reg;

        if (stop_det) begin
            state_next      = IDLE;
            dio_oe_next     = 1'b0;
            frame_done_next = acked_reg;
        end else if (start_det) begin
            state_next      = RX_BYTE;
            bit_cnt_next    = '0;
            first_byte_next = 1'b1;
            acked_next      = 1'b0;
            frame_kind_next = FK_IGNORE;
            dio_oe_next     = 1'b0;
        end else begin
            case (state_reg)
                RX_BYTE: begin
                    if (clk_rise && bit_cnt_reg < 4'd8) begin
                        rx_byte_next[bit_cnt_reg[2:0]] = dio_s;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (clk_fall && bit_cnt_reg == 4'd8) begin
                        state_next  = RX_ACK;
                        dio_oe_next = 1'b1;
                    end
                end
                RX_ACK: begin
                    // ACK is held low through the 9th clock; the byte takes effect on its falling edge
                    if (clk_fall) begin
                        state_next      = RX_BYTE;
                        dio_oe_next     = 1'b0;
                        acked_next      = 1'b1;
                        first_byte_next = 1'b0;
                        bit_cnt_next    = '0;
                        if (first_byte_reg) begin
                            case (rx_byte_reg[7:6])
                                2'b01: begin
                                    fixed_next = rx_byte_reg[2];
                                    if (rx_byte_reg[1]) begin
                                        state_next   = TX_BYTE;
                                        tx_byte_next = key_data;
                                        dio_oe_next  = ~key_data[0];
                                        bit_cnt_next = 4'd1;
                                    end
                                end
                                2'b11: begin
                                    ptr_next = {1'b0, rx_byte_reg[2:0]};
                                    if ({1'b0, rx_byte_reg[2:0]} >= DEPTH) begin
                                        cmd_err_next    = 1'b1;
                                        frame_kind_next = FK_DISCARD;
                                    end else begin
                                        frame_kind_next = FK_ADDR;
                                    end
                                end
                                2'b10: begin
                                    display_on_next = rx_byte_reg[3];
                                    brightness_next = rx_byte_reg[2:0];
                                end
                                default: begin
                                    cmd_err_next = 1'b1;
                                    state_next   = WAIT_STOP;
                                end
                            endcase
                        end else if (frame_kind_reg == FK_ADDR) begin
                            if (ptr_reg < DEPTH) begin
                                ram_we = 1'b1;
                                if (!fixed_reg) ptr_next = ptr_reg + 4'd1;
                            end else begin
                                cmd_err_next = 1'b1;
                            end
                        end
                    end
                end
                TX_BYTE: begin
                    if (clk_fall) begin
                        if (bit_cnt_reg < 4'd8) begin
                            dio_oe_next  = ~tx_byte_reg[bit_cnt_reg[2:0]];
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                        end else begin
                            dio_oe_next = 1'b0;
                            state_next  = TX_ACK;
                        end
                    end
                end
                TX_ACK: begin
                    if (clk_fall) state_next = WAIT_STOP;
                end
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [7:0] digit_reg;
            always_ff @(posedge clk_50M or negedge rst_n) begin
                if (!rst_n) digit_reg <= '0;
                else if (ram_we && ram_waddr == 3'(gi)) digit_reg <= ram_wdata;
            end
            assign digits[gi] = digit_reg;
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (rd_addr == 3'(i)) rd_data = digits[i];
        end
    end

    assign dio_oe     = dio_oe_reg;
    assign display_on = display_on_reg;
    assign brightness = brightness_reg;
    assign frame_done = frame_done_reg;
    assign cmd_err    = cmd_err_reg;

endmodule

// File: tb/tb_tm1637_responder.sv
// Directed bench for tm1637_responder: drives an open-drain CLK/DIO initiator and
// checks ACKs, RAM contents, display control, key read-back, error and frame pulses.
module tb_tm1637_responder;

    localparam int HALF = 10;

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic       tm_clk;
    logic       dio_drv;
    logic       tm_dio;
    logic       dio_oe;
    logic [7:0] key_data;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       display_on;
    logic [2:0] brightness;
    logic       frame_done;
    logic       cmd_err;

    int compared   = 0;
    int mismatched = 0;
    int fd_cnt     = 0;
    int err_cnt    = 0;
    int oe_cnt     = 0;

    assign tm_dio = dio_drv & ~dio_oe;

    always #10 clk_50M = ~clk_50M;

    tm1637_responder #(.SYNC_STAGES(2), .NUM_DIGITS(6)) dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .tm_clk_in  (tm_clk),
        .tm_dio_in  (tm_dio),
        .dio_oe     (dio_oe),
        .key_data   (key_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .display_on (display_on),
        .brightness (brightness),
        .frame_done (frame_done),
        .cmd_err    (cmd_err)
    );

    always @(posedge clk_50M) begin
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (cmd_err)    err_cnt <= err_cnt + 1;
        if (dio_oe)     oe_cnt <= oe_cnt + 1;
    end

    task automatic half_wait();
        repeat (HALF) @(negedge clk_50M);
    endtask

    task automatic tm_start();
        dio_drv = 1'b1; tm_clk = 1'b1; half_wait();
        dio_drv = 1'b0; half_wait();
        tm_clk = 1'b0; half_wait();
    endtask

    task automatic tm_stop();
        tm_clk = 1'b0; dio_drv = 1'b0; half_wait();
        tm_clk = 1'b1; half_wait();
        dio_drv = 1'b1; half_wait();
        half_wait();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic oe_after);
        for (int i = 0; i < 8; i++) begin
            dio_drv = b[i]; half_wait();
            tm_clk = 1'b1; half_wait();
            tm_clk = 1'b0;
        end
        dio_drv = 1'b1; half_wait();
        compared++;
        if (dio_oe !== 1'b1) begin
            mismatched++;
            $display("FAIL ack_pre byte=%02h dio_oe=%b want 1", b, dio_oe);
        end
        tm_clk = 1'b1; half_wait();
        compared++;
        if (tm_dio !== 1'b0) begin
            mismatched++;
            $display("FAIL ack_9th byte=%02h dio=%b want 0", b, tm_dio);
        end
        tm_clk = 1'b0; half_wait();
        compared++;
        if (dio_oe !== oe_after) begin
            mismatched++;
            $display("FAIL ack_post byte=%02h dio_oe=%b want %b", b, dio_oe, oe_after);
        end
        $display("byte %02h sent", b);
    endtask

    task automatic test_reset();
        compared++;
        if ({dio_oe, display_on, brightness, frame_done, cmd_err} !== 7'b0) begin
            mismatched++;
            $display("FAIL reset_outs got=%b want 0000000",
                     {dio_oe, display_on, brightness, frame_done, cmd_err});
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i); #1;
            compared++;
            if (rd_data !== 8'h00) begin
                mismatched++;
                $display("FAIL reset_ram[%0d] got=%02h want 00", i, rd_data);
            end
        end
        $display("reset checked");
    endtask

    task automatic test_write_auto();
        logic [7:0] exp [3] = '{8'h3F, 8'h06, 8'h5B};
        int fd0;
        fd0 = fd_cnt;
        tm_start(); send_byte(8'h40, 1'b0); tm_stop();
        tm_start(); send_byte(8'hC0, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(exp[i], 1'b0);
        tm_stop();
        for (int i = 0; i < 3; i++) begin
            rd_addr = 3'(i); #1;
            compared++;
            if (rd_data !== exp[i]) begin
                mismatched++;
                $display("FAIL auto_ram[%0d] got=%02h want %02h", i, rd_data, exp[i]);
            end
        end
        compared++;
        if (fd_cnt - fd0 !== 2) begin
            mismatched++;
            $display("FAIL auto_frame_done got=%0d want 2", fd_cnt - fd0);
        end
        $display("write auto-increment done");
    endtask

    task automatic test_fixed();
        int e0;
        e0 = err_cnt;
        tm_start(); send_byte(8'h44, 1'b0); tm_stop();
        tm_start(); send_byte(8'hC3, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); tm_stop();
        rd_addr = 3'd3; #1;
        compared++;
        if (rd_data !== 8'h22) begin
            mismatched++;
            $display("FAIL fixed_ram3 got=%02h want 22", rd_data);
        end
        rd_addr = 3'd4; #1;
        compared++;
        if (rd_data !== 8'h00) begin
            mismatched++;
            $display("FAIL fixed_ram4 got=%02h want 00", rd_data);
        end
        compared++;
        if (err_cnt !== e0) begin
            mismatched++;
            $display("FAIL fixed_err got=%0d want 0", err_cnt - e0);
        end
        $display("fixed address done");
    endtask

    task automatic test_overflow();
        int e0;
        tm_start(); send_byte(8'h40, 1'b0); tm_stop();
        e0 = err_cnt;
        tm_start(); send_byte(8'hC4, 1'b0);
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
        tm_stop();
        rd_addr = 3'd4; #1;
        compared++;
        if (rd_data !== 8'hAA) begin
            mismatched++;
            $display("FAIL ovf_ram4 got=%02h want AA", rd_data);
        end
        rd_addr = 3'd5; #1;
        compared++;
        if (rd_data !== 8'hBB) begin
            mismatched++;
            $display("FAIL ovf_ram5 got=%02h want BB", rd_data);
        end
        rd_addr = 3'd6; #1;
        compared++;
        if (rd_data !== 8'h00) begin
            mismatched++;
            $display("FAIL ovf_ram6 got=%02h want 00", rd_data);
        end
        compared++;
        if (err_cnt - e0 !== 1) begin
            mismatched++;
            $display("FAIL ovf_err got=%0d want 1", err_cnt - e0);
        end
        $display("overflow done");
    endtask

    task automatic test_errors();
        int e0;
        int fd0;
        e0 = err_cnt;
        tm_start(); send_byte(8'hC7, 1'b0); send_byte(8'h55, 1'b0); tm_stop();
        compared++;
        if (err_cnt - e0 !== 1) begin
            mismatched++;
            $display("FAIL bad_addr_err got=%0d want 1", err_cnt - e0);
        end
        e0 = err_cnt;
        tm_start(); send_byte(8'h00, 1'b0); tm_stop();
        compared++;
        if (err_cnt - e0 !== 1) begin
            mismatched++;
            $display("FAIL cmd00_err got=%0d want 1", err_cnt - e0);
        end
        fd0 = fd_cnt;
        tm_start(); tm_stop();
        compared++;
        if (fd_cnt !== fd0) begin
            mismatched++;
            $display("FAIL empty_frame_done got=%0d want 0", fd_cnt - fd0);
        end
        $display("error cases done");
    endtask

    task automatic test_display();
        tm_start(); send_byte(8'h8C, 1'b0); tm_stop();
        compared++;
        if ({display_on, brightness} !== 4'b1100) begin
            mismatched++;
            $display("FAIL disp_on got=%b want 1100", {display_on, brightness});
        end
        tm_start(); send_byte(8'h80, 1'b0); tm_stop();
        compared++;
        if ({display_on, brightness} !== 4'b0000) begin
            mismatched++;
            $display("FAIL disp_off got=%b want 0000", {display_on, brightness});
        end
        $display("display control done");
    endtask

    task automatic test_key_read();
        logic [7:0] seen;
        int fd0;
        fd0 = fd_cnt;
        key_data = 8'hA5;
        tm_start(); send_byte(8'h42, 1'b0);
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            dio_drv = 1'b1;
            tm_clk = 1'b1; half_wait();
            seen[i] = tm_dio;
            tm_clk = 1'b0; half_wait();
        end
        compared++;
        if (seen !== 8'hA5) begin
            mismatched++;
            $display("FAIL key_bits got=%02h want A5", seen);
        end
        compared++;
        if (dio_oe !== 1'b0) begin
            mismatched++;
            $display("FAIL key_release got=%b want 0", dio_oe);
        end
        tm_stop();
        compared++;
        if (dio_oe !== 1'b0 || fd_cnt - fd0 !== 1) begin
            mismatched++;
            $display("FAIL key_stop dio_oe=%b frames=%0d want 0/1", dio_oe, fd_cnt - fd0);
        end
        $display("key read done seen=%02h", seen);
    endtask

    task automatic test_reset_mid_ack();
        logic [7:0] b;
        int oe0;
        b = 8'hC0;
        tm_start();
        for (int i = 0; i < 8; i++) begin
            dio_drv = b[i]; half_wait();
            tm_clk = 1'b1; half_wait();
            tm_clk = 1'b0;
        end
        dio_drv = 1'b1; half_wait();
        compared++;
        if (dio_oe !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_ack_pre got=%b want 1", dio_oe);
        end
        #3 rst_n = 1'b0; #1;
        compared++;
        if (dio_oe !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_ack_reset got=%b want 0", dio_oe);
        end
        half_wait();
        rst_n = 1'b1; half_wait();
        oe0 = oe_cnt;
        b = 8'h77;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 9; i++) begin
                dio_drv = (i < 8) ? b[i] : 1'b1; half_wait();
                tm_clk = 1'b1; half_wait();
                tm_clk = 1'b0;
            end
        end
        half_wait();
        compared++;
        if (oe_cnt !== oe0) begin
            mismatched++;
            $display("FAIL nostart_oe got=%0d cycles want 0", oe_cnt - oe0);
        end
        for (int i = 0; i < 6; i++) begin
            rd_addr = 3'(i); #1;
            compared++;
            if (rd_data !== 8'h00) begin
                mismatched++;
                $display("FAIL nostart_ram[%0d] got=%02h want 00", i, rd_data);
            end
        end
        $display("reset mid-ack done");
    endtask

    initial begin
        rst_n = 1'b0; tm_clk = 1'b1; dio_drv = 1'b1; key_data = 8'h00; rd_addr = 3'd0;
        repeat (5) @(negedge clk_50M);
        test_reset();
        rst_n = 1'b1;
        half_wait();
        test_write_auto();
        test_fixed();
        test_overflow();
        test_errors();
        test_display();
        test_key_read();
        test_reset_mid_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
